// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

  // True when an operand of bin_w bits can exceed 10^digits-1, i.e. ovf can ever be set.
  function automatic bit ovf_possible(int unsigned bin_w, int unsigned digits);
    longint unsigned p;
    longint unsigned max_val;
    if (bin_w >= 60) return 1'b1;
    max_val = (64'd1 << bin_w) - 64'd1;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
      if (p > max_val) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD scratch digit of 5 or more.
module bin2bcd_seq_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] digit_adj_c
);

  assign digit_adj_c = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one operand bit per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam bit          OVF_POSSIBLE = ovf_possible(BIN_W, DIGITS);

  if (BIN_W < 1 || DIGITS < 1) begin : g_param_check
    $error("bin2bcd_seq: BIN_W and DIGITS must both be at least 1");
  end

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIN_W-1:0] bin_sr, bin_sr_nxt;
  logic [BCD_W-1:0] dig_sr, dig_sr_nxt;
  logic             ovf_acc, ovf_acc_nxt;
  logic             busy_nxt, done_nxt, ovf_nxt;
  logic [BCD_W-1:0] bcd_out_nxt;

  logic [BCD_W-1:0] dig_adj;
  logic [BCD_W-1:0] dig_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             carry_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_seq_digit_adj u_adj (
      .digit       (dig_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_adj_c (dig_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One double-dabble step: shift {digits, bin} left by one after correction.
  assign carry_out = dig_adj[BCD_W-1];
  assign dig_shift = BCD_W'({dig_adj, bin_sr[BIN_W-1]});
  assign bin_shift = BIN_W'({bin_sr, 1'b0});

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bin_sr_nxt  = bin_sr;
    dig_sr_nxt  = dig_sr;
    ovf_acc_nxt = ovf_acc;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    bcd_out_nxt = bcd_out;
    ovf_nxt     = ovf;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          bin_sr_nxt  = bin_in;
          dig_sr_nxt  = '0;
          ovf_acc_nxt = 1'b0;
          cnt_nxt     = CNT_W'(BIN_W);
          busy_nxt    = 1'b1;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_sr_nxt  = bin_shift;
        dig_sr_nxt  = dig_shift;
        ovf_acc_nxt = ovf_acc | carry_out;
        cnt_nxt     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_out_nxt = dig_shift;
          ovf_nxt     = OVF_POSSIBLE & (ovf_acc | carry_out);
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      dig_sr  <= '0;
      ovf_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bin_sr  <= bin_sr_nxt;
      dig_sr  <= dig_sr_nxt;
      ovf_acc <= ovf_acc_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bcd_out <= bcd_out_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: a 3-digit and a 2-digit instance on one clock.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Accept one operand on the next rising edge, then wait (bounded) for done.
  // lat = falling edges from the accept edge up to and including the done cycle.
  task automatic convert(input bit sel, input logic [7:0] v, input int repulse_at,
                         output logic [11:0] res, output logic ov,
                         output int lat, output int busy_cyc);
    bit seen;
    seen = 1'b0;
    lat = -1;
    busy_cyc = 0;
    res = '0;
    ov = 1'b0;
    if (sel) begin start_b = 1'b1; bin_b = v; end
    else     begin start_a = 1'b1; bin_a = v; end
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    bin_a = 8'hA5; bin_b = 8'h5A;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == repulse_at) begin start_a = 1'b1; bin_a = 8'd7; end
      else begin start_a = 1'b0; bin_a = 8'hA5; end
      if ((sel ? done_b : done_a) == 1'b1) begin
        seen = 1'b1;
        lat = i;
        res = sel ? {4'h0, bcd_b} : bcd_a;
        ov  = sel ? ovf_b : ovf_a;
        check("busy_low_at_done", 32'(sel ? busy_b : busy_a), 32'd0);
      end else if ((sel ? busy_b : busy_a) == 1'b1) begin
        busy_cyc++;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic run(input bit sel, input logic [7:0] v, input logic [11:0] exp_bcd,
                     input bit exp_ovf, input string tag, input bit b2b);
    logic [11:0] res;
    logic        ov;
    int          lat, bc;
    if (!b2b) @(negedge clk);
    convert(sel, v, 0, res, ov, lat, bc);
    check({tag, "_bcd"}, 32'(res), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(ov), 32'(exp_ovf));
    check({tag, "_lat"}, 32'(lat), 32'd9);
  endtask

  initial begin
    logic [11:0] res;
    logic        ov;
    int          lat, bc, extra;
    logic [7:0]  bcd45, bcd38;
    logic [4:0]  usum;
    logic [3:0]  sum_d;
    logic        carry;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);

    // Full-scale operand, latency, busy width and done pulse width.
    convert(1'b0, 8'd255, 0, res, ov, lat, bc);
    check("t1_bcd", 32'(res), 32'h255);
    check("t1_ovf", 32'(ov), 32'd0);
    check("t1_lat", 32'(lat), 32'd9);
    check("t1_busy_cycles", 32'(bc), 32'd8);
    @(negedge clk);
    check("t1_done_pulse", 32'(done_a), 32'd0);
    check("t1_bcd_hold", 32'(bcd_a), 32'h255);

    run(1'b0, 8'd0,   12'h000, 1'b0, "t2_0",   1'b0);
    run(1'b0, 8'd99,  12'h099, 1'b0, "t2_99",  1'b0);
    run(1'b0, 8'd100, 12'h100, 1'b0, "t2_100", 1'b0);

    // Start re-pulsed during busy must be ignored.
    @(negedge clk);
    convert(1'b0, 8'd123, 3, res, ov, lat, bc);
    check("t3_bcd", 32'(res), 32'h123);
    check("t3_lat", 32'(lat), 32'd9);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    check("t3_no_second_done", 32'(extra), 32'd0);

    // Back-to-back: start presented in the done cycle of the previous conversion.
    run(1'b0, 8'd250, 12'h250, 1'b0, "t4_first", 1'b0);
    run(1'b0, 8'd42,  12'h042, 1'b0, "t4_b2b",   1'b1);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_done", 32'(done_a), 32'd0);
    check("t5_bcd", 32'(bcd_a), 32'd0);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    check("t5_no_done", 32'(extra), 32'd0);

    // Two-digit instance: overflow boundaries and the units digits for the adder.
    run(1'b1, 8'd200, 12'h000, 1'b1, "t6_200", 1'b0);
    run(1'b1, 8'd99,  12'h099, 1'b0, "t6_99",  1'b0);
    run(1'b1, 8'd100, 12'h000, 1'b1, "t6_100", 1'b0);
    run(1'b1, 8'd255, 12'h055, 1'b1, "t6_255", 1'b0);
    run(1'b1, 8'd45,  12'h045, 1'b0, "t6_45",  1'b0);
    bcd45 = bcd_b;
    run(1'b1, 8'd38,  12'h038, 1'b0, "t6_38",  1'b0);
    bcd38 = bcd_b;
    usum  = {1'b0, bcd45[3:0]} + {1'b0, bcd38[3:0]};
    carry = (usum > 5'd9);
    sum_d = carry ? 4'(usum - 5'd10) : usum[3:0];
    check("t6_units_sum", 32'(sum_d), 32'h3);
    check("t6_units_carry", 32'(carry), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
